// File: rtl/point_on_curve_check.sv
// Checks y^2 == x^3 - x + 1 over GF(3^97), p(t) = t^97 + t^12 + 2, using one serial f3m_mult.
// Build option: define POINT_CHECK_CANON_EN to reject operands holding a 2'b11 coefficient.
`ifndef WIDTH
`define WIDTH 193
`endif

package f3m_pkg;
  localparam int M   = 97;
  localparam int EW  = `WIDTH + 1;
  localparam int TAP = 12;
  typedef logic [EW-1:0] elem_t;

  // 2'b11 is folded onto zero so every helper is total.
  function automatic logic [1:0] gf3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, (a == 2'b11) ? 2'b00 : a} + {1'b0, (b == 2'b11) ? 2'b00 : b};
    if (s >= 3'd3) begin
      s = s - 3'd3;
    end else begin
      s = s;
    end
    return s[1:0];
  endfunction

  function automatic logic [1:0] gf3_neg(input logic [1:0] a);
    logic [1:0] r;
    case (a)
      2'b01:   r = 2'b10;
      2'b10:   r = 2'b01;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] gf3_mul(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    if (a == 2'b00 || a == 2'b11 || b == 2'b00 || b == 2'b11) begin
      r = 2'b00;
    end else if (a == b) begin
      r = 2'b01;
    end else begin
      r = 2'b10;
    end
    return r;
  endfunction

  function automatic elem_t elem_add(input elem_t a, input elem_t b);
    elem_t r;
    r = '0;
    for (int i = 0; i < M; i++) r[2*i +: 2] = gf3_add(a[2*i +: 2], b[2*i +: 2]);
    return r;
  endfunction

  function automatic elem_t elem_sub(input elem_t a, input elem_t b);
    elem_t r;
    r = '0;
    for (int i = 0; i < M; i++) r[2*i +: 2] = gf3_add(a[2*i +: 2], gf3_neg(b[2*i +: 2]));
    return r;
  endfunction

  function automatic elem_t elem_scale(input elem_t a, input logic [1:0] c);
    elem_t r;
    r = '0;
    for (int i = 0; i < M; i++) r[2*i +: 2] = gf3_mul(a[2*i +: 2], c);
    return r;
  endfunction

  // Multiply by t: t^97 folds back as 2*t^12 + 1.
  function automatic elem_t elem_mul_t(input elem_t a);
    elem_t      r;
    logic [1:0] top;
    top = a[EW-1 -: 2];
    r = {a[EW-3:0], 2'b00};
    r[1:0] = top;
    r[2*TAP +: 2] = gf3_add(r[2*TAP +: 2], gf3_neg(top));
    return r;
  endfunction

  // Cubing is linear in characteristic 3: spread a_i to t^(3i), then reduce top-down.
  function automatic elem_t elem_cube(input elem_t a);
    logic [1:0] w [3*M-2];
    logic [1:0] c;
    elem_t      r;
    r = '0;
    for (int i = 0; i < 3*M-2; i++) w[i] = 2'b00;
    for (int i = 0; i < M; i++) w[3*i] = a[2*i +: 2];
    for (int d = 3*M-3; d >= M; d--) begin
      c = w[d];
      w[d-M] = gf3_add(w[d-M], c);
      w[d-M+TAP] = gf3_add(w[d-M+TAP], gf3_neg(c));
    end
    for (int i = 0; i < M; i++) r[2*i +: 2] = w[i];
    return r;
  endfunction

  function automatic logic elem_noncanon(input elem_t a);
    logic r;
    r = 1'b0;
    for (int i = 0; i < M; i++) r = r | (a[2*i +: 2] == 2'b11);
    return r;
  endfunction
endpackage

module f3m_add (
  input  logic [`WIDTH:0] a_i,
  input  logic [`WIDTH:0] b_i,
  output logic [`WIDTH:0] c_o
);
  import f3m_pkg::*;
  assign c_o = elem_add(a_i, b_i);
endmodule

module f3m_sub (
  input  logic [`WIDTH:0] a_i,
  input  logic [`WIDTH:0] b_i,
  output logic [`WIDTH:0] c_o
);
  import f3m_pkg::*;
  assign c_o = elem_sub(a_i, b_i);
endmodule

module f3m_cubic (
  input  logic [`WIDTH:0] a_i,
  output logic [`WIDTH:0] c_o
);
  import f3m_pkg::*;
  assign c_o = elem_cube(a_i);
endmodule

// Serial MSB-first multiplier: operands captured while reset_i is high, one coefficient of b per cycle.
module f3m_mult (
  input  logic            clk,
  input  logic            reset_i,
  input  logic [`WIDTH:0] a_i,
  input  logic [`WIDTH:0] b_i,
  output logic [`WIDTH:0] c_o,
  output logic            done_o
);
  import f3m_pkg::*;
  localparam logic [6:0] STEPS = 7'd97;

  elem_t      a_q, b_q, acc_q, b_d, acc_d;
  logic [6:0] cnt_q, cnt_d;
  logic       done_q;

  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    if (cnt_q != STEPS) begin
      acc_d = elem_add(elem_mul_t(acc_q), elem_scale(a_q, b_q[EW-1 -: 2]));
      b_d   = {b_q[EW-3:0], 2'b00};
      cnt_d = cnt_q + 7'd1;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      acc_q  <= '0;
      cnt_q  <= 7'd0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_q;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == STEPS);
    end
  end

  assign c_o    = acc_q;
  assign done_o = done_q;
endmodule

module point_on_curve_check (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [`WIDTH:0] x,
  input  logic [`WIDTH:0] y,
  input  logic            zero,
  output logic            busy,
  output logic            done,
  output logic            valid
);
  import f3m_pkg::*;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MULT = 3'd2,
    CMP  = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam elem_t ELEM_ONE = {{(EW-1){1'b0}}, 1'b1};

  state_t state_q;
  elem_t  xr_q, yr_q, y2r_q;
  logic   zr_q, busy_q, done_q, valid_q;
  elem_t  prod_d, cube_d, cube_mx_d, rhs_d;
  logic   mult_rst_d, mult_done_d, verdict_d;

  assign mult_rst_d = reset | (state_q == LOAD);

  f3m_mult u_mult (
    .clk    (clk),
    .reset_i(mult_rst_d),
    .a_i    (yr_q),
    .b_i    (yr_q),
    .c_o    (prod_d),
    .done_o (mult_done_d)
  );

  f3m_cubic u_cubic (.a_i(xr_q),      .c_o(cube_d));
  f3m_sub   u_sub   (.a_i(cube_d),    .b_i(xr_q),     .c_o(cube_mx_d));
  f3m_add   u_add   (.a_i(cube_mx_d), .b_i(ELEM_ONE), .c_o(rhs_d));

  assign verdict_d = zr_q | (y2r_q == rhs_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      y2r_q   <= '0;
      zr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            xr_q   <= x;
            yr_q   <= y;
            zr_q   <= zero;
            busy_q <= 1'b1;
            if (zero) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              valid_q <= 1'b1;
            end else begin
              state_q <= LOAD;
              valid_q <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD: begin
`ifdef POINT_CHECK_CANON_EN
          if (!zr_q && (elem_noncanon(xr_q) || elem_noncanon(yr_q))) begin
            state_q <= FIN;
            done_q  <= 1'b1;
            valid_q <= 1'b0;
          end else begin
            state_q <= MULT;
          end
`else
          state_q <= MULT;
`endif
        end
        MULT: begin
          if (mult_done_d) begin
            y2r_q   <= prod_d;
            state_q <= CMP;
          end else begin
            state_q <= MULT;
          end
        end
        CMP: begin
          state_q <= FIN;
          done_q  <= 1'b1;
          valid_q <= verdict_d;
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_point_on_curve_check.sv
// Bench for point_on_curve_check: directed jobs plus random points against a schoolbook GF(3^97) model.
module tb_point_on_curve_check;
  localparam int M        = 97;
  localparam int EW       = 2*M;
  localparam int LM       = 98;  // f3m_mult reset edge to the edge that samples its done
  localparam int NORM_LAT = 3 + LM;
  typedef logic [EW-1:0] el_t;

  logic clk = 1'b0;
  logic reset, start, zero, busy, done, valid;
  el_t  x, y;
  int   total = 0;
  int   bad   = 0;

  point_on_curve_check dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .zero(zero),
    .busy(busy), .done(done), .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic el_t m_one();
    el_t r;
    r = '0;
    r[0] = 1'b1;
    return r;
  endfunction

  function automatic el_t m_const(input int c);
    el_t r;
    r = '0;
    r[1:0] = 2'(c);
    return r;
  endfunction

  function automatic el_t m_rand();
    el_t r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'($urandom_range(2, 0));
    return r;
  endfunction

  function automatic el_t m_add(input el_t a, input el_t b);
    el_t r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'((int'(a[2*i +: 2]) + int'(b[2*i +: 2])) % 3);
    return r;
  endfunction

  function automatic el_t m_sub(input el_t a, input el_t b);
    el_t r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'((int'(a[2*i +: 2]) + 3 - int'(b[2*i +: 2])) % 3);
    return r;
  endfunction

  // Full polynomial product, then reduction with t^97 = 2 t^12 + 1.
  function automatic el_t m_mul(input el_t a, input el_t b);
    int  p [2*M-1];
    int  c;
    el_t r;
    for (int i = 0; i < 2*M-1; i++) p[i] = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        p[i+j] += int'(a[2*i +: 2]) * int'(b[2*j +: 2]);
    for (int d = 2*M-2; d >= M; d--) begin
      c = p[d] % 3;
      p[d] = 0;
      p[d-M] += c;
      p[d-M+12] += 2*c;
    end
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'(p[i] % 3);
    return r;
  endfunction

  function automatic el_t m_rhs(input el_t a);
    return m_add(m_sub(m_mul(m_mul(a, a), a), a), m_one());
  endfunction

  function automatic logic m_on_curve(input el_t a, input el_t b, input logic z);
    return z || (m_mul(b, b) == m_rhs(a));
  endfunction

  function automatic el_t m_pow(input el_t a, input logic [159:0] e);
    el_t r;
    r = m_one();
    for (int i = 159; i >= 0; i--) begin
      r = m_mul(r, r);
      if (e[i]) r = m_mul(r, a);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_job(input string tag, input el_t jx, input el_t jy, input logic jz,
                        input int exp_lat, input logic exp_v, input logic chk_v);
    int   lat;
    logic b1, v1;
    @(negedge clk);
    x = jx; y = jy; zero = jz; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; x = m_rand(); y = m_rand(); zero = 1'b0;
    b1 = busy; v1 = valid;
    lat = 1;
    while (done !== 1'b1 && lat < exp_lat + 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " busy_on_accept"}, 32'(b1), 32'd1);
    if (!jz) check({tag, " valid_cleared"}, 32'(v1), 32'd0);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    if (chk_v) check({tag, " verdict"}, 32'(valid), 32'(exp_v));
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " busy_clear"}, 32'(busy), 32'd0);
    if (chk_v) check({tag, " valid_held"}, 32'(valid), 32'(exp_v));
  endtask

  initial begin
    el_t          rx, ry, rhs;
    logic [159:0] sq_e;
    int           found, first_lat, ndone;
    logic         v_first;

    reset = 1'b1; start = 1'b0; zero = 1'b0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("idle busy", 32'(busy), 32'd0);
      check("idle done", 32'(done), 32'd0);
      check("idle valid", 32'(valid), 32'd0);
    end

    do_job("p(0,1)", '0, m_one(), 1'b0, NORM_LAT, 1'b1, 1'b1);
    do_job("p(1,1)", m_one(), m_one(), 1'b0, NORM_LAT, 1'b1, 1'b1);
    do_job("p(0,2)", '0, m_const(2), 1'b0, NORM_LAT, 1'b1, 1'b1);
    do_job("p(2,1)", m_const(2), m_one(), 1'b0, NORM_LAT, 1'b1, 1'b1);
    do_job("p(0,0)", '0, '0, 1'b0, NORM_LAT, 1'b0, 1'b1);
    do_job("inf", m_rand(), m_rand(), 1'b1, 1, 1'b1, 1'b1);

    for (int n = 0; n < 3; n++) begin
      rx = m_rand(); ry = m_rand();
      do_job("rand", rx, ry, 1'b0, NORM_LAT, m_on_curve(rx, ry, 1'b0), 1'b1);
    end

    // q = 3^97 is 3 mod 4, so a square root of r is r^((q+1)/4).
    sq_e = 160'd1;
    for (int i = 0; i < M; i++) sq_e = sq_e * 160'd3;
    sq_e = (sq_e + 160'd1) >> 2;
    found = 0;
    for (int tries = 0; tries < 16 && found < 2; tries++) begin
      rx  = m_rand();
      rhs = m_rhs(rx);
      ry  = m_pow(rhs, sq_e);
      if (m_mul(ry, ry) == rhs) begin
        found++;
        do_job("curve", rx, ry, 1'b0, NORM_LAT, 1'b1, 1'b1);
        ry = m_add(ry, el_t'(1) << 10);
        do_job("offcurve", rx, ry, 1'b0, NORM_LAT, m_on_curve(rx, ry, 1'b0), 1'b1);
      end
    end
    check("curve points found", 32'(found > 0), 32'd1);

    // Extra start pulses while busy carry operands that are off the curve.
    @(negedge clk);
    x = m_one(); y = m_one(); zero = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; x = '0; y = '0;
    first_lat = -1; ndone = 0; v_first = 1'b0;
    for (int k = 1; k <= NORM_LAT + 40; k++) begin
      if (done === 1'b1) begin
        ndone++;
        if (first_lat < 0) begin
          first_lat = k;
          v_first = valid;
        end
      end
      @(negedge clk);
      start = (k % 9 == 4) && (first_lat < 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("ignore latency", 32'(first_lat), 32'(NORM_LAT));
    check("ignore verdict", 32'(v_first), 32'd1);
    check("ignore done count", 32'(ndone), 32'd1);

    // Reset in the middle of the multiply aborts the job silently.
    @(negedge clk);
    x = '0; y = m_one(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort valid", 32'(valid), 32'd0);
    @(negedge clk); reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < LM + 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);
    do_job("post-abort", '0, m_one(), 1'b0, NORM_LAT, 1'b1, 1'b1);

    // Start together with reset is dropped.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; x = '0; y = m_one();
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("start under reset", 32'(busy), 32'd0);

`ifdef POINT_CHECK_CANON_EN
    do_job("noncanon", m_const(3), m_one(), 1'b0, 2, 1'b0, 1'b1);
`else
    do_job("noncanon", m_const(3), m_one(), 1'b0, NORM_LAT, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
